mul_sched: RTL

Sequencer and round-robin arbiter that shares one iterative 32x32 signed Booth multiplier among up to four requesters. Each request carries two operands, and the block pulses the multiplier's start. It waits for completion, then returns the 64-bit product tagged with the requester id. A watchdog turns a stuck multiplier into an error response. The block sits between the issue logic and the multiplier instance. The multiplier itself stays outside this block.

---
 rtl/mul_sched_pkg.sv | 27 ++
 rtl/mul_sched_if.sv | 39 +++
 rtl/mul_sched_rr_arb.sv | 47 ++++
 rtl/mul_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared types and helpers for the multiplier scheduler.
//   state_e : sequencer states (IDLE, START, WAIT, RESP)
//   ID_W    : width of a requester index
//   rr_next : advances the round-robin pointer, wrapping at nreq
package mul_sched_pkg;

    localparam int ID_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Index that gets first look in the next arbitration round.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] last, input int nreq);
        logic [ID_W-1:0] nxt;
        if (int'(last) >= nreq - 1) begin
            nxt = '0;
        end else begin
            nxt = last + ID_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mul_sched_if.sv
// mul_sched_if: bundles the request, response and multiplier-side signals of
// the scheduler.
//   slave  : view used by mul_sched (takes requests, drives the multiplier)
//   master : view used by the surroundings (issue logic, consumer, multiplier)
// Requester i occupies req_a/req_b[i*WIDTH +: WIDTH].
interface mul_sched_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32
);
    import mul_sched_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  rsp_err;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_product;
    logic                  mul_done;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_product, mul_done,
        output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
               mul_start, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_product, mul_done,
        input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
               mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/mul_sched_rr_arb.sv
// rr_arb: combinational round-robin arbiter.
//   req        : request vector
//   last_grant : index granted most recently
//   grant      : one-hot grant (zero when nothing requests)
//   grant_idx  : index of the granted bit (0 when nothing requests)
// Search starts at last_grant+1 (mod NREQ); each candidate is ranked by its
// distance from that start and the closest requester wins.
module rr_arb
    import mul_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    int   ptr_s;
    int   best_s;
    int   dist_s;
    logic take_s;

    // Pick the requester closest to the round-robin start point.
    always_comb begin
        ptr_s     = int'(rr_next(last_grant, NREQ));
        best_s    = NREQ;
        dist_s    = 0;
        take_s    = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            dist_s    = (i - ptr_s + NREQ) % NREQ;
            take_s    = req[i] && (dist_s < best_s);
            best_s    = take_s ? dist_s : best_s;
            grant_idx = take_s ? ID_W'(i) : grant_idx;
        end
    end

    // Expand the winning index to a one-hot vector.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = (best_s < NREQ) && (grant_idx == ID_W'(i));
        end
    end

endmodule

// File: rtl/mul_sched.sv
// mul_sched: shares one iterative signed multiplier among NREQ requesters.
//   clk, reset : clock and synchronous active-high reset
//   bus.req_*  : per-requester valid/ready with packed operands
//   bus.rsp_*  : product response tagged with the requester id; rsp_err marks
//                a watchdog timeout (product forced to 0)
//   bus.mul_*  : start pulse, operands, product and done of the multiplier
// Flow: IDLE (arbitrate/accept) -> START (pulse) -> WAIT (done or watchdog)
//       -> RESP (hold until consumer takes it) -> IDLE.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset,
    mul_sched_if.slave bus
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [ID_W-1:0]    last_grant_r;
    logic [NREQ-1:0]    grant_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [NREQ-1:0]    req_ready_s;
    logic               rsp_valid_s;
    logic               mul_start_s;
    logic               accept_s;
    logic               done_hit_s;
    logic               timeout_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic               armed_r;
    logic [7:0]         cnt_r;
    logic [WIDTH-1:0]   mul_a_r;
    logic [WIDTH-1:0]   mul_b_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic [2*WIDTH-1:0] rsp_product_r;
    logic               rsp_err_r;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    // Operands of the granted requester.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_a_s = grant_s[i] ? bus.req_a[i*WIDTH +: WIDTH] : sel_a_s;
            sel_b_s = grant_s[i] ? bus.req_b[i*WIDTH +: WIDTH] : sel_b_s;
        end
    end

    // Completion qualifiers; the first WAIT cycle (armed_r=0) ignores the stale idle done.
    always_comb begin
        done_hit_s = (state_r == WAIT) && armed_r && bus.mul_done;
        timeout_s  = (state_r == WAIT) && !done_hit_s && (cnt_r == TO_LAST);
        accept_s   = |req_ready_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (done_hit_s || timeout_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM outputs; req_ready is held low while reset is asserted.
    always_comb begin
        req_ready_s = '0;
        rsp_valid_s = 1'b0;
        mul_start_s = 1'b0;
        case (state_r)
            IDLE:    req_ready_s = reset ? '0 : grant_s;
            START:   mul_start_s = 1'b1;
            WAIT:    mul_start_s = 1'b0;
            RESP:    rsp_valid_s = 1'b1;
            default: rsp_valid_s = 1'b0;
        endcase
    end

    // Capture operands, owner id and round-robin history on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a_r      <= '0;
            mul_b_r      <= '0;
            rsp_id_r     <= '0;
            last_grant_r <= ID_W'(NREQ - 1);
        end else if (accept_s) begin
            mul_a_r      <= sel_a_s;
            mul_b_r      <= sel_b_s;
            rsp_id_r     <= grant_idx_s;
            last_grant_r <= grant_idx_s;
        end
    end

    // Watchdog counter and arm flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= 8'd0;
            armed_r <= 1'b0;
        end else begin
            case (state_r)
                START: begin
                    cnt_r   <= 8'd0;
                    armed_r <= 1'b0;
                end
                WAIT: begin
                    cnt_r   <= cnt_r + 8'd1;
                    armed_r <= 1'b1;
                end
                default: begin
                    cnt_r   <= cnt_r;
                    armed_r <= armed_r;
                end
            endcase
        end
    end

    // Response payload: product on completion, zero with error on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_product_r <= '0;
            rsp_err_r     <= 1'b0;
        end else if (done_hit_s) begin
            rsp_product_r <= bus.mul_product;
            rsp_err_r     <= 1'b0;
        end else if (timeout_s) begin
            rsp_product_r <= '0;
            rsp_err_r     <= 1'b1;
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.rsp_valid   = rsp_valid_s;
    assign bus.rsp_id      = rsp_id_r;
    assign bus.rsp_product = rsp_product_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.mul_start   = mul_start_s;
    assign bus.mul_a       = mul_a_r;
    assign bus.mul_b       = mul_b_r;

endmodule
